// File: rtl/data_mem_access_unit.sv
// Memory-stage load/store initiator: maps byte addresses to {row, col}, runs
// read-modify-write for sub-doubleword stores and extends load data.
module data_mem_access_unit #(
  parameter int unsigned MEM_ROWS = 32,
  parameter int unsigned MEM_COLS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] mem_address,
  output logic [63:0] mem_writeData,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_readData
);

  localparam int unsigned ENTRIES = MEM_ROWS * MEM_COLS;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        store_q, signed_q, fault_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q, wdata_q, line_q, rdata_q;

  logic        misaligned_c, out_of_range_c, fault_c;
  logic [2:0]  align_mask_c;
  logic [60:0] entry_c, row_c, col_c;
  logic [63:0] mem_addr_c;

  // Lane extraction with zero/sign extension from the lane MSB.
  function automatic logic [63:0] load_extract(input logic [63:0] d, input logic [2:0] off,
                                               input logic [1:0] sz, input logic sgn);
    logic [63:0] lane;
    lane = d >> {off, 3'b000};
    case (sz)
      2'd0:    load_extract = sgn ? {{56{lane[7]}},  lane[7:0]}  : {56'b0, lane[7:0]};
      2'd1:    load_extract = sgn ? {{48{lane[15]}}, lane[15:0]} : {48'b0, lane[15:0]};
      2'd2:    load_extract = sgn ? {{32{lane[31]}}, lane[31:0]} : {32'b0, lane[31:0]};
      default: load_extract = lane;
    endcase
  endfunction

  // Replace the addressed bytes of the captured doubleword with low bytes of wdata.
  function automatic logic [63:0] store_merge(input logic [63:0] line, input logic [63:0] wd,
                                              input logic [2:0] off, input logic [1:0] sz);
    logic [63:0] mask;
    case (sz)
      2'd0:    mask = 64'h0000_0000_0000_00FF;
      2'd1:    mask = 64'h0000_0000_0000_FFFF;
      2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    mask        = mask << {off, 3'b000};
    store_merge = (line & ~mask) | ((wd << {off, 3'b000}) & mask);
  endfunction

  // Accept-time fault check on the raw request.
  always_comb begin
    case (req_size)
      2'd0:    align_mask_c = 3'b000;
      2'd1:    align_mask_c = 3'b001;
      2'd2:    align_mask_c = 3'b011;
      default: align_mask_c = 3'b111;
    endcase
    misaligned_c   = (req_addr[2:0] & align_mask_c) != 3'b000;
    out_of_range_c = req_addr[63:3] >= 61'(ENTRIES);
    fault_c        = misaligned_c | out_of_range_c;
  end

  // Row/column mapping of the latched address.
  always_comb begin
    entry_c    = addr_q[63:3];
    row_c      = entry_c / 61'(MEM_COLS);
    col_c      = entry_c % 61'(MEM_COLS);
    mem_addr_c = {32'(row_c), 32'(col_c)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (fault_c)                         state_d = RESP;
          else if (req_store && req_size == 2'd3) state_d = WR;
          else                                 state_d = RD;
        end
      end
      RD:      state_d = store_q ? WR : RESP;
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, read capture and load result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      fault_q  <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      line_q   <= 64'd0;
      rdata_q  <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            fault_q  <= fault_c;
            rdata_q  <= 64'd0;
          end
        end
        RD: begin
          line_q <= mem_readData;
          if (!store_q) rdata_q <= load_extract(mem_readData, addr_q[2:0], size_q, signed_q);
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; everything forced low while rst_n is low.
  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = 64'd0;
    resp_fault    = 1'b0;
    mem_address   = 64'd0;
    mem_writeData = 64'd0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: req_ready = 1'b1;
        RD: begin
          mem_read    = 1'b1;
          mem_address = mem_addr_c;
        end
        WR: begin
          mem_write     = 1'b1;
          mem_address   = mem_addr_c;
          mem_writeData = store_merge(line_q, wdata_q, addr_q[2:0], size_q);
        end
        default: begin
          resp_valid = 1'b1;
          resp_rdata = rdata_q;
          resp_fault = fault_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit with a 32x32 doubleword memory model.
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [63:0] resp_rdata;
  logic [63:0] mem_address, mem_writeData, mem_readData;
  logic        mem_read, mem_write;

  logic [63:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [63:0] pre_data;
  logic [9:0]  midx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] b2b_data [0:2];

  data_mem_access_unit #(.MEM_ROWS(32), .MEM_COLS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_read(mem_read), .mem_write(mem_write), .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  // Memory model: row*32+col, combinational read, write on rising edge.
  assign midx         = {mem_address[36:32], mem_address[4:0]};
  assign mem_readData = mem_read ? mem[midx] : 64'h0;

  always @(posedge clk) begin
    if (pre_we)    mem[pre_idx] <= pre_data;
    if (mem_write) mem[midx]    <= mem_writeData;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input int i, input logic [63:0] d);
    pre_we   = 1'b1;
    pre_idx  = 10'(i);
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Present one request in IDLE; returns at the negedge of cycle N+1.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd);
    chk("ready_before_req", 64'(req_ready), 64'd1);
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    pre_we = 1'b0; pre_idx = 10'd0; pre_data = 64'd0;
    b2b_data[0] = 64'hA0A1A2A3A4A5A6A7;
    b2b_data[1] = 64'hB0B1B2B3B4B5B6B7;
    b2b_data[2] = 64'hC0C1C2C3C4C5C6C7;
    repeat (2) @(negedge clk);

    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_fault", 64'(resp_fault), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_address", mem_address, 64'd0);
    chk("rst_mem_wdata", mem_writeData, 64'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 64'(req_ready), 64'd1);
    @(negedge clk);

    // Doubleword store to entry 33 (row 1, col 1)
    issue(1'b1, 2'd3, 1'b0, 64'h108, 64'h1122334455667788);
    chk("dw_st_write", 64'(mem_write), 64'd1);
    chk("dw_st_read", 64'(mem_read), 64'd0);
    chk("dw_st_addr", mem_address, {32'd1, 32'd1});
    chk("dw_st_wdata", mem_writeData, 64'h1122334455667788);
    chk("dw_st_busy", 64'(req_ready), 64'd0);
    chk("dw_st_no_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("dw_st_resp", 64'(resp_valid), 64'd1);
    chk("dw_st_fault", 64'(resp_fault), 64'd0);
    chk("dw_st_rdata", resp_rdata, 64'd0);
    chk("dw_st_write_off", 64'(mem_write), 64'd0);
    chk("dw_st_mem", mem[33], 64'h1122334455667788);
    @(negedge clk);

    // Doubleword load back
    issue(1'b0, 2'd3, 1'b0, 64'h108, 64'd0);
    chk("dw_ld_read", 64'(mem_read), 64'd1);
    chk("dw_ld_addr", mem_address, {32'd1, 32'd1});
    @(negedge clk);
    chk("dw_ld_resp", 64'(resp_valid), 64'd1);
    chk("dw_ld_rdata", resp_rdata, 64'h1122334455667788);
    @(negedge clk);

    // Byte/half loads with extension
    preload(0, 64'h00000000000080FF);
    issue(1'b0, 2'd0, 1'b1, 64'h1, 64'd0);
    @(negedge clk);
    chk("lb_signed", resp_rdata, 64'hFFFFFFFFFFFFFF80);
    @(negedge clk);
    issue(1'b0, 2'd0, 1'b0, 64'h1, 64'd0);
    @(negedge clk);
    chk("lb_unsigned", resp_rdata, 64'h80);
    @(negedge clk);
    issue(1'b0, 2'd1, 1'b1, 64'h0, 64'd0);
    @(negedge clk);
    chk("lh_signed", resp_rdata, 64'hFFFFFFFFFFFF80FF);
    @(negedge clk);

    // Half store read-modify-write
    preload(0, 64'h1122334455667788);
    issue(1'b1, 2'd1, 1'b0, 64'h6, 64'h000000000000BEEF);
    chk("sh_rd_read", 64'(mem_read), 64'd1);
    chk("sh_rd_write", 64'(mem_write), 64'd0);
    @(negedge clk);
    chk("sh_wr_write", 64'(mem_write), 64'd1);
    chk("sh_wr_read", 64'(mem_read), 64'd0);
    chk("sh_wr_addr", mem_address, 64'd0);
    chk("sh_wr_wdata", mem_writeData, 64'hBEEF334455667788);
    chk("sh_wr_no_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("sh_resp", 64'(resp_valid), 64'd1);
    chk("sh_mem", mem[0], 64'hBEEF334455667788);
    @(negedge clk);

    // Byte store ignores upper wdata bytes
    issue(1'b1, 2'd0, 1'b0, 64'h3, 64'hFFFFFFFFFFFFFFAB);
    @(negedge clk);
    chk("sb_wr_wdata", mem_writeData, 64'hBEEF3344AB667788);
    @(negedge clk);
    chk("sb_resp", 64'(resp_valid), 64'd1);
    @(negedge clk);

    // Signed word load from upper half
    issue(1'b0, 2'd2, 1'b1, 64'h4, 64'd0);
    @(negedge clk);
    chk("lw_signed", resp_rdata, 64'hFFFFFFFFBEEF3344);
    @(negedge clk);

    // Faults: misaligned word, out of range, misaligned store
    issue(1'b0, 2'd2, 1'b0, 64'h2, 64'd0);
    chk("flt_mis_resp", 64'(resp_valid), 64'd1);
    chk("flt_mis_fault", 64'(resp_fault), 64'd1);
    chk("flt_mis_rdata", resp_rdata, 64'd0);
    chk("flt_mis_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    @(negedge clk);
    issue(1'b0, 2'd3, 1'b0, 64'h2000, 64'd0);
    chk("flt_oor_resp", 64'(resp_valid), 64'd1);
    chk("flt_oor_fault", 64'(resp_fault), 64'd1);
    chk("flt_oor_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    @(negedge clk);
    issue(1'b1, 2'd1, 1'b0, 64'h101, 64'h1234);
    chk("flt_st_fault", 64'(resp_fault), 64'd1);
    chk("flt_st_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    @(negedge clk);

    // Last valid entry (row 31, col 31)
    preload(1023, 64'hCAFEF00DDEADBEEF);
    issue(1'b0, 2'd3, 1'b0, 64'h1FF8, 64'd0);
    chk("edge_addr", mem_address, {32'd31, 32'd31});
    @(negedge clk);
    chk("edge_fault", 64'(resp_fault), 64'd0);
    chk("edge_rdata", resp_rdata, 64'hCAFEF00DDEADBEEF);
    @(negedge clk);

    // Back-to-back loads with req_valid held high
    preload(1, b2b_data[0]);
    preload(2, b2b_data[1]);
    preload(3, b2b_data[2]);
    req_store = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      chk("b2b_ready", 64'(req_ready), (c % 3 == 0) ? 64'd1 : 64'd0);
      chk("b2b_resp", 64'(resp_valid), (c % 3 == 2) ? 64'd1 : 64'd0);
      if (c % 3 == 2) chk("b2b_rdata", resp_rdata, b2b_data[c / 3]);
      if (c % 3 == 0) req_addr = 64'(8 * (c / 3 + 1));
      else            req_addr = 64'hDEAD_0000_0000_0003;
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Reset asserted in the RD cycle of a byte store
    preload(5, 64'h0123456789ABCDEF);
    issue(1'b1, 2'd0, 1'b0, 64'h28, 64'h55);
    chk("rst_mid_pre_read", 64'(mem_read), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_read", 64'(mem_read), 64'd0);
    chk("rst_mid_write", 64'(mem_write), 64'd0);
    chk("rst_mid_addr", mem_address, 64'd0);
    chk("rst_mid_resp", 64'(resp_valid), 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("rst_hold_write", 64'(mem_write), 64'd0);
    chk("rst_hold_resp", 64'(resp_valid), 64'd0);
    rst_n = 1'b1;
    #1 chk("rst_rel_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    chk("rst_rel_write", 64'(mem_write), 64'd0);
    chk("rst_rel_resp", 64'(resp_valid), 64'd0);
    chk("rst_mem_intact", mem[5], 64'h0123456789ABCDEF);
    issue(1'b0, 2'd3, 1'b0, 64'h28, 64'd0);
    @(negedge clk);
    chk("post_rst_resp", 64'(resp_valid), 64'd1);
    chk("post_rst_rdata", resp_rdata, 64'h0123456789ABCDEF);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
